// File: rtl/slave_resp_mux.sv
// Registered slave read-data mux: latches a select on request, waits for that
// slave's ack (with optional timeout) and holds the captured data on mux_out.
module slave_resp_mux #(
    parameter int                 NUM_SLAVES = 4,
    parameter int                 DATA_W     = 32,
    parameter int                 SEL_W      = 2,
    parameter int                 TIMEOUT    = 15,
    parameter logic [DATA_W-1:0]  ERR_DATA   = DATA_W'(32'hDEADBEEF)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic [SEL_W-1:0]             sel,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLAVES-1:0]        slv_ack,
    output logic                         busy,
    output logic [DATA_W-1:0]            mux_out,
    output logic                         done,
    output logic                         err
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CW-1:0]     count, count_d;
    logic [DATA_W-1:0] mux_d;
    logic              done_d, err_d;
    logic              ack_sel;
    logic [DATA_W-1:0] rdata_sel;
    logic              sel_ok;

    // Constant-index compare chain keeps non-power-of-two slave counts in range.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ack_sel   = slv_ack[i];
                rdata_sel = slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_ok = (int'(sel) < NUM_SLAVES);

    always_comb begin
        state_d = state;
        sel_d   = sel_q;
        count_d = count;
        mux_d   = mux_out;
        done_d  = 1'b0;
        err_d   = err;
        case (state)
            IDLE: begin
                if (req) begin
                    if (sel_ok) begin
                        sel_d   = sel;
                        count_d = '0;
                        state_d = WAIT;
                    end else begin
                        mux_d  = ERR_DATA;
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Ack on the final timeout edge still wins over the error.
                if (ack_sel) begin
                    mux_d   = rdata_sel;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT != 0 && count == CW'(TIMEOUT - 1)) begin
                    mux_d   = ERR_DATA;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    count_d = count + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            count   <= '0;
            mux_out <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            sel_q   <= sel_d;
            count   <= count_d;
            mux_out <= mux_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    assign busy = (state == WAIT);

endmodule
